// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Width needed to hold a latency value 0..lat inclusive.
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding selects, load-use/branch/MDU stalls, MDU latency scoreboard and
// per-cause stall counters for the 5-stage pipeline.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_decode,
  input  logic [ADDR_W-1:0] rs_decode,
  input  logic [ADDR_W-1:0] rt_decode,
  input  logic [ADDR_W-1:0] rs_exe,
  input  logic [ADDR_W-1:0] rt_exe,
  input  logic              regwrite_exe,
  input  logic              memtoreg_exe,
  input  logic [ADDR_W-1:0] regaddr_exe,
  input  logic              regwrite_mem,
  input  logic              memtoreg_mem,
  input  logic [ADDR_W-1:0] regaddr_mem,
  input  logic              regwrite_wb,
  input  logic [ADDR_W-1:0] regaddr_wb,
  input  logic              hilo_read_decode,
  input  logic              mdu_start_decode,
  input  logic              mdu_start_exe,
  input  logic              mdu_div_exe,
  input  logic              mdu_kill,
  input  logic              stat_clr,
  output logic              stall_pc,
  output logic              stall_decode,
  output logic              flush_exe,
  output logic              forwardA_decode,
  output logic              forwardB_decode,
  output logic [1:0]        forwardA_exe,
  output logic [1:0]        forwardB_exe,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [STAT_W-1:0] cnt_lw,
  output logic [STAT_W-1:0] cnt_branch,
  output logic [STAT_W-1:0] cnt_mdu
);

  localparam int CW = cnt_width(DIV_LAT);

  logic [CW-1:0] cnt;
  logic          lwstall;
  logic          branchstall;
  logic          mdustall;
  logic          stall;
  logic          exe_hit;
  logic          mem_hit;

  // MEM has the younger value, so it wins over WB.
  always_comb begin
    forwardA_exe = FWD_RF;
    if ((rs_exe != '0) && regwrite_mem && (rs_exe == regaddr_mem)) begin
      forwardA_exe = FWD_MEM;
    end else if ((rs_exe != '0) && regwrite_wb && (rs_exe == regaddr_wb)) begin
      forwardA_exe = FWD_WB;
    end
  end

  always_comb begin
    forwardB_exe = FWD_RF;
    if ((rt_exe != '0) && regwrite_mem && (rt_exe == regaddr_mem)) begin
      forwardB_exe = FWD_MEM;
    end else if ((rt_exe != '0) && regwrite_wb && (rt_exe == regaddr_wb)) begin
      forwardB_exe = FWD_WB;
    end
  end

  assign forwardA_decode = (rs_decode != '0) && (rs_decode == regaddr_mem) && regwrite_mem;
  assign forwardB_decode = (rt_decode != '0) && (rt_decode == regaddr_mem) && regwrite_mem;

  assign lwstall = memtoreg_exe && (regaddr_exe != '0) &&
                   ((regaddr_exe == rs_decode) || (regaddr_exe == rt_decode));

  assign exe_hit = regwrite_exe && (regaddr_exe != '0) &&
                   ((regaddr_exe == rs_decode) || (regaddr_exe == rt_decode));
  assign mem_hit = memtoreg_mem && (regaddr_mem != '0) &&
                   ((regaddr_mem == rs_decode) || (regaddr_mem == rt_decode));
  assign branchstall = branch_decode && (exe_hit || mem_hit);

  // The start term covers the cycle before the scoreboard has loaded.
  assign mdustall = (hilo_read_decode || mdu_start_decode) && (mdu_busy || mdu_start_exe);

  assign stall        = lwstall || branchstall || mdustall;
  assign stall_pc     = stall;
  assign stall_decode = stall;
  assign flush_exe    = stall;

  assign mdu_busy = (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      mdu_done <= 1'b0;
    end else begin
      mdu_done <= 1'b0;
      if (mdu_kill) begin
        cnt <= '0;
      end else if (mdu_start_exe) begin
        cnt <= mdu_div_exe ? CW'(DIV_LAT) : CW'(MUL_LAT);
      end else if (cnt != '0) begin
        cnt      <= cnt - CW'(1);
        mdu_done <= (cnt == CW'(1));
      end
    end
  end

  sat_counter #(.W(STAT_W)) u_cnt_lw (
    .clk(clk), .rst(rst), .inc(lwstall), .clr(stat_clr), .count(cnt_lw)
  );

  sat_counter #(.W(STAT_W)) u_cnt_branch (
    .clk(clk), .rst(rst), .inc(branchstall), .clr(stat_clr), .count(cnt_branch)
  );

  sat_counter #(.W(STAT_W)) u_cnt_mdu (
    .clk(clk), .rst(rst), .inc(mdustall), .clr(stat_clr), .count(cnt_mdu)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench: default-width instance plus a 4-bit-counter
// instance sharing the same stimulus for the saturation case.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst;
  logic branch_decode;
  logic [4:0] rs_decode, rt_decode, rs_exe, rt_exe;
  logic regwrite_exe, memtoreg_exe;
  logic [4:0] regaddr_exe;
  logic regwrite_mem, memtoreg_mem;
  logic [4:0] regaddr_mem;
  logic regwrite_wb;
  logic [4:0] regaddr_wb;
  logic hilo_read_decode, mdu_start_decode, mdu_start_exe, mdu_div_exe, mdu_kill, stat_clr;

  logic stall_pc, stall_decode, flush_exe, forwardA_decode, forwardB_decode;
  logic [1:0] forwardA_exe, forwardB_exe;
  logic mdu_busy, mdu_done;
  logic [15:0] cnt_lw, cnt_branch, cnt_mdu;

  logic s_stall_pc, s_stall_decode, s_flush_exe, s_fwda_d, s_fwdb_d;
  logic [1:0] s_fwda_e, s_fwdb_e;
  logic s_busy, s_done;
  logic [3:0] s_cnt_lw, s_cnt_branch, s_cnt_mdu;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .branch_decode(branch_decode),
    .rs_decode(rs_decode), .rt_decode(rt_decode), .rs_exe(rs_exe), .rt_exe(rt_exe),
    .regwrite_exe(regwrite_exe), .memtoreg_exe(memtoreg_exe), .regaddr_exe(regaddr_exe),
    .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem), .regaddr_mem(regaddr_mem),
    .regwrite_wb(regwrite_wb), .regaddr_wb(regaddr_wb),
    .hilo_read_decode(hilo_read_decode), .mdu_start_decode(mdu_start_decode),
    .mdu_start_exe(mdu_start_exe), .mdu_div_exe(mdu_div_exe), .mdu_kill(mdu_kill),
    .stat_clr(stat_clr),
    .stall_pc(stall_pc), .stall_decode(stall_decode), .flush_exe(flush_exe),
    .forwardA_decode(forwardA_decode), .forwardB_decode(forwardB_decode),
    .forwardA_exe(forwardA_exe), .forwardB_exe(forwardB_exe),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .cnt_lw(cnt_lw), .cnt_branch(cnt_branch), .cnt_mdu(cnt_mdu)
  );

  hazard_scoreboard #(.STAT_W(4)) dut_s (
    .clk(clk), .rst(rst), .branch_decode(branch_decode),
    .rs_decode(rs_decode), .rt_decode(rt_decode), .rs_exe(rs_exe), .rt_exe(rt_exe),
    .regwrite_exe(regwrite_exe), .memtoreg_exe(memtoreg_exe), .regaddr_exe(regaddr_exe),
    .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem), .regaddr_mem(regaddr_mem),
    .regwrite_wb(regwrite_wb), .regaddr_wb(regaddr_wb),
    .hilo_read_decode(hilo_read_decode), .mdu_start_decode(mdu_start_decode),
    .mdu_start_exe(mdu_start_exe), .mdu_div_exe(mdu_div_exe), .mdu_kill(mdu_kill),
    .stat_clr(stat_clr),
    .stall_pc(s_stall_pc), .stall_decode(s_stall_decode), .flush_exe(s_flush_exe),
    .forwardA_decode(s_fwda_d), .forwardB_decode(s_fwdb_d),
    .forwardA_exe(s_fwda_e), .forwardB_exe(s_fwdb_e),
    .mdu_busy(s_busy), .mdu_done(s_done),
    .cnt_lw(s_cnt_lw), .cnt_branch(s_cnt_branch), .cnt_mdu(s_cnt_mdu)
  );

  // A start while the scoreboard is busy must never be issued by the pipeline.
  always @(negedge clk) begin
    if (!rst && mdu_start_exe && mdu_busy) begin
      bad++;
      $display("FAIL start_while_busy got=1 exp=0");
    end
  end

  task automatic idle();
    branch_decode = 0; rs_decode = 0; rt_decode = 0; rs_exe = 0; rt_exe = 0;
    regwrite_exe = 0; memtoreg_exe = 0; regaddr_exe = 0;
    regwrite_mem = 0; memtoreg_mem = 0; regaddr_mem = 0;
    regwrite_wb = 0; regaddr_wb = 0;
    hilo_read_decode = 0; mdu_start_decode = 0; mdu_start_exe = 0;
    mdu_div_exe = 0; mdu_kill = 0; stat_clr = 0;
  endtask

  // Advance one cycle; inputs driven afterwards belong to the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #12;
    total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", mdu_busy); end
    total++; if (mdu_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", mdu_done); end
    total++; if (stall_pc !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", stall_pc); end
    total++; if (cnt_lw !== 16'd0 || cnt_branch !== 16'd0 || cnt_mdu !== 16'd0) begin
      bad++; $display("FAIL rst_counters got=%0d/%0d/%0d exp=0/0/0", cnt_lw, cnt_branch, cnt_mdu);
    end
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic test_ex_forward();
    idle();
    rs_exe = 8; rt_exe = 8;
    regwrite_mem = 1; regaddr_mem = 8;
    regwrite_wb = 1; regaddr_wb = 8;
    settle();
    total++; if (forwardA_exe !== 2'b10) begin bad++; $display("FAIL fwdA_mem_prio got=%b exp=10", forwardA_exe); end
    regwrite_mem = 0;
    settle();
    total++; if (forwardA_exe !== 2'b01) begin bad++; $display("FAIL fwdA_wb got=%b exp=01", forwardA_exe); end
    total++; if (forwardB_exe !== 2'b01) begin bad++; $display("FAIL fwdB_wb got=%b exp=01", forwardB_exe); end
    rs_exe = 0; regwrite_mem = 1; regaddr_mem = 0; regaddr_wb = 0;
    settle();
    total++; if (forwardA_exe !== 2'b00) begin bad++; $display("FAIL fwdA_r0 got=%b exp=00", forwardA_exe); end
    rt_exe = 5; regaddr_mem = 6; regaddr_wb = 5; regwrite_wb = 0;
    settle();
    total++; if (forwardB_exe !== 2'b00) begin bad++; $display("FAIL fwdB_nowrite got=%b exp=00", forwardB_exe); end
    total++; if (stall_pc !== 1'b0) begin bad++; $display("FAIL fwd_nostall got=%b exp=0", stall_pc); end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    memtoreg_exe = 1; regwrite_exe = 1; regaddr_exe = 9; rt_decode = 9;
    settle();
    total++; if ({stall_pc, stall_decode, flush_exe} !== 3'b111) begin
      bad++; $display("FAIL lw_stall got=%b exp=111", {stall_pc, stall_decode, flush_exe});
    end
    tick();
    idle();
    settle();
    total++; if (cnt_lw !== 16'd1) begin bad++; $display("FAIL lw_count got=%0d exp=1", cnt_lw); end
    total++; if (stall_pc !== 1'b0) begin bad++; $display("FAIL lw_release got=%b exp=0", stall_pc); end
    memtoreg_exe = 1; regwrite_exe = 1; regaddr_exe = 0; rt_decode = 9; rs_decode = 0;
    settle();
    total++; if (stall_pc !== 1'b0) begin bad++; $display("FAIL lw_r0 got=%b exp=0", stall_pc); end
    tick();
    idle();
    settle();
    total++; if (cnt_lw !== 16'd1) begin bad++; $display("FAIL lw_r0_count got=%0d exp=1", cnt_lw); end
  endtask

  task automatic test_branch();
    idle();
    branch_decode = 1; rs_decode = 3; rt_decode = 4;
    regwrite_exe = 1; regaddr_exe = 3;
    settle();
    total++; if (stall_pc !== 1'b1) begin bad++; $display("FAIL br_exe_stall got=%b exp=1", stall_pc); end
    tick();
    regwrite_exe = 0; regaddr_exe = 0;
    regwrite_mem = 1; regaddr_mem = 3; memtoreg_mem = 0;
    settle();
    total++; if (forwardA_decode !== 1'b1) begin bad++; $display("FAIL br_fwdA got=%b exp=1", forwardA_decode); end
    total++; if (forwardB_decode !== 1'b0) begin bad++; $display("FAIL br_fwdB got=%b exp=0", forwardB_decode); end
    total++; if (stall_pc !== 1'b0) begin bad++; $display("FAIL br_alu_mem got=%b exp=0", stall_pc); end
    memtoreg_mem = 1;
    settle();
    total++; if (stall_pc !== 1'b1) begin bad++; $display("FAIL br_load_mem got=%b exp=1", stall_pc); end
    tick();
    idle();
    branch_decode = 1; rs_decode = 0; regwrite_exe = 1; regaddr_exe = 0;
    settle();
    total++; if (stall_pc !== 1'b0) begin bad++; $display("FAIL br_r0 got=%b exp=0", stall_pc); end
    tick();
    idle();
    settle();
    total++; if (cnt_branch !== 16'd2) begin bad++; $display("FAIL br_count got=%0d exp=2", cnt_branch); end
  endtask

  task automatic test_div_mfhi();
    int busy_err = 0;
    int stall_err = 0;
    int done_err = 0;
    idle();
    mdu_start_exe = 1; mdu_div_exe = 1; hilo_read_decode = 1;
    settle();
    total++; if (stall_pc !== 1'b1 || mdu_busy !== 1'b0) begin
      bad++; $display("FAIL div_T got stall=%b busy=%b exp stall=1 busy=0", stall_pc, mdu_busy);
    end
    tick();
    mdu_start_exe = 0; mdu_div_exe = 0;
    for (int k = 1; k <= 32; k++) begin
      settle();
      if (mdu_busy !== 1'b1) busy_err++;
      if (stall_pc !== 1'b1) stall_err++;
      if (mdu_done !== 1'b0) done_err++;
      tick();
    end
    total++; if (busy_err != 0) begin bad++; $display("FAIL div_busy_window got=%0d_bad_cycles exp=0", busy_err); end
    total++; if (stall_err != 0) begin bad++; $display("FAIL div_stall_window got=%0d_bad_cycles exp=0", stall_err); end
    total++; if (done_err != 0) begin bad++; $display("FAIL div_early_done got=%0d_bad_cycles exp=0", done_err); end
    settle();
    total++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b1 || stall_pc !== 1'b0) begin
      bad++; $display("FAIL div_end got busy=%b done=%b stall=%b exp 0/1/0", mdu_busy, mdu_done, stall_pc);
    end
    total++; if (cnt_mdu !== 16'd33) begin bad++; $display("FAIL div_cnt_mdu got=%0d exp=33", cnt_mdu); end
    tick();
    settle();
    total++; if (mdu_done !== 1'b0) begin bad++; $display("FAIL div_done_pulse got=%b exp=0", mdu_done); end
    idle();
  endtask

  task automatic test_multiply();
    int busy_err = 0;
    idle();
    mdu_start_exe = 1; mdu_div_exe = 0;
    tick();
    mdu_start_exe = 0;
    for (int k = 1; k <= 4; k++) begin
      settle();
      if (mdu_busy !== 1'b1 || mdu_done !== 1'b0) busy_err++;
      tick();
    end
    total++; if (busy_err != 0) begin bad++; $display("FAIL mul_busy_window got=%0d_bad_cycles exp=0", busy_err); end
    settle();
    total++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b1) begin
      bad++; $display("FAIL mul_end got busy=%b done=%b exp 0/1", mdu_busy, mdu_done);
    end
    tick();
  endtask

  task automatic test_kill();
    idle();
    mdu_start_exe = 1; mdu_div_exe = 1; hilo_read_decode = 1;
    tick();
    mdu_start_exe = 0; mdu_div_exe = 0;
    for (int k = 2; k <= 5; k++) tick();
    mdu_kill = 1;
    settle();
    total++; if (mdu_busy !== 1'b1 || stall_pc !== 1'b1) begin
      bad++; $display("FAIL kill_T5 got busy=%b stall=%b exp 1/1", mdu_busy, stall_pc);
    end
    tick();
    mdu_kill = 0;
    settle();
    total++; if (mdu_busy !== 1'b0 || stall_pc !== 1'b0 || mdu_done !== 1'b0) begin
      bad++; $display("FAIL kill_T6 got busy=%b stall=%b done=%b exp 0/0/0", mdu_busy, stall_pc, mdu_done);
    end
    tick();
    settle();
    total++; if (mdu_done !== 1'b0) begin bad++; $display("FAIL kill_no_done got=%b exp=0", mdu_done); end
    idle();
    mdu_kill = 1; mdu_start_exe = 1; mdu_div_exe = 1;
    tick();
    idle();
    settle();
    total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL kill_prio got=%b exp=0", mdu_busy); end
  endtask

  task automatic test_sat_clear();
    idle();
    memtoreg_exe = 1; regaddr_exe = 7; rs_decode = 7; stat_clr = 1;
    tick();
    stat_clr = 0;
    settle();
    total++; if (cnt_lw !== 16'd0 || s_cnt_lw !== 4'd0) begin
      bad++; $display("FAIL clr_prio got=%0d/%0d exp=0/0", cnt_lw, s_cnt_lw);
    end
    for (int k = 0; k < 20; k++) tick();
    settle();
    total++; if (s_cnt_lw !== 4'd15) begin bad++; $display("FAIL sat_4bit got=%0d exp=15", s_cnt_lw); end
    total++; if (cnt_lw !== 16'd20) begin bad++; $display("FAIL sat_16bit got=%0d exp=20", cnt_lw); end
    idle();
    stat_clr = 1;
    tick();
    stat_clr = 0;
    settle();
    total++; if (cnt_lw !== 16'd0 || s_cnt_lw !== 4'd0 || cnt_mdu !== 16'd0 || cnt_branch !== 16'd0) begin
      bad++; $display("FAIL stat_clr got=%0d/%0d/%0d/%0d exp=0", cnt_lw, s_cnt_lw, cnt_mdu, cnt_branch);
    end
  endtask

  task automatic test_rst_mid();
    idle();
    mdu_start_exe = 1; hilo_read_decode = 1;
    tick();
    mdu_start_exe = 0;
    tick();
    settle();
    total++; if (mdu_busy !== 1'b1 || stall_pc !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre got busy=%b stall=%b exp 1/1", mdu_busy, stall_pc);
    end
    rst = 1;
    #1;
    total++; if (mdu_busy !== 1'b0 || stall_pc !== 1'b0) begin
      bad++; $display("FAIL rst_mid_async got busy=%b stall=%b exp 0/0", mdu_busy, stall_pc);
    end
    total++; if (cnt_mdu !== 16'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", cnt_mdu); end
    @(negedge clk);
    rst = 0;
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_load_use();
    test_branch();
    test_div_mfhi();
    test_multiply();
    test_kill();
    test_sat_clear();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard/forwarding controller for the 5-stage MIPS pipeline. It generates the EX- and ID-stage forwarding selects, the load-use and branch-operand stalls, and a new class of stall for the multi-cycle multiply/divide unit (MDU). MDU busy state is tracked by an internal latency scoreboard. It also keeps saturating per-cause stall counters for performance analysis. It sits beside the datapath and drives the PC, IF/ID and ID/EX stall/flush enables.

## Interface
- `ADDR_W`, 5, register-address width
- `MUL_LAT`, 4, cycles the MDU is busy after a multiply starts (≥1)
- `DIV_LAT`, 32, cycles the MDU is busy after a divide starts (≥1, ≥`MUL_LAT`)
- `STAT_W`, 16, width of each stall counter
---
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `branch_decode`  in  1  ID-stage instruction is a branch or jr
- `rs_decode`, `rt_decode`  in  `ADDR_W`  ID source registers
- `rs_exe`, `rt_exe`  in  `ADDR_W`  EX source registers
- `regwrite_exe`, `memtoreg_exe`  in  1  EX-stage control
- `regaddr_exe`  in  `ADDR_W`  EX destination
- `regwrite_mem`, `memtoreg_mem`  in  1  MEM-stage control
- `regaddr_mem`  in  `ADDR_W`  MEM destination
- `regwrite_wb`  in  1  WB-stage write enable
- `regaddr_wb`  in  `ADDR_W`  WB destination
- `hilo_read_decode`  in  1  ID instruction is mfhi/mflo
- `mdu_start_decode`  in  1  ID instruction is mult/multu/div/divu
- `mdu_start_exe`  in  1  an MDU op is in EX this cycle
- `mdu_div_exe`  in  1  the EX MDU op is a divide (1) or a multiply (0)
- `mdu_kill`  in  1  exception: abort the MDU operation in flight
- `stat_clr`  in  1  synchronous clear of all stall counters
- `stall_pc`, `stall_decode`, `flush_exe`  out  1  pipeline control
- `forwardA_decode`, `forwardB_decode`  out  1  ID comparator forwarding from MEM
- `forwardA_exe`, `forwardB_exe`  out  2  EX forwarding: 00 reg file, 01 WB, 10 MEM
- `mdu_busy`  out  1  MDU result not yet valid
- `mdu_done`  out  1  registered one-cycle pulse when busy falls naturally
- `cnt_lw`, `cnt_branch`, `cnt_mdu`  out  `STAT_W`  saturating stall-cycle counters

## Operation
- **EX forwarding:** MEM match has priority over WB match. A match requires source ≠ 0, address equality and the matching stage's regwrite=1.
- **ID forwarding:** `forwardX_decode` = (src ≠ 0) & (src == `regaddr_mem`) & `regwrite_mem`.
- **lwstall:** `memtoreg_exe` & (`regaddr_exe` ≠ 0) & (`regaddr_exe` == `rs_decode` | `regaddr_exe` == `rt_decode`).
  - Register 0 never stalls.
  - Uses `regaddr_exe`, not `rt_exe`.
- **branchstall:** `branch_decode` & [(`regwrite_exe` & `regaddr_exe` matches a source) | (`memtoreg_mem` & `regaddr_mem` matches a source)].
  - The matched address must be ≠ 0.
- **MDU scoreboard:** a down-counter `cnt` of width clog2(`DIV_LAT`+1).
  - Loads `DIV_LAT` or `MUL_LAT` on an edge where `mdu_start_exe`=1.
  - Otherwise decrements while ≠ 0.
  - `mdu_busy` = (`cnt` ≠ 0).
- **mdustall:** (`hilo_read_decode` | `mdu_start_decode`) & (`mdu_busy` | `mdu_start_exe`).
  - The `mdu_start_exe` term covers the cycle before the counter loads.
- **stall:** `stall` = lwstall | branchstall | mdustall. `stall_pc` = `stall_decode` = `flush_exe` = `stall`.
- **mdu_done:** registered, set for one cycle after an edge where `cnt` goes 1→0.
  - Not set on kill or reset.
- **mdu_kill:** forces `cnt` to 0 on the next edge. It has priority over a simultaneous `mdu_start_exe`.
- **Start while busy:** `mdu_start_exe` while `mdu_busy` cannot occur, because the decode stall prevents it.
  - If it does occur, the counter reloads.
  - Verification flags it as an assertion failure.
- **Stall counters:** each counter increments on every cycle its own cause is asserted. Overlapping causes each count.
  - Each counter saturates at all-ones.
  - `stat_clr` zeroes all three and has priority over increment.
- **Reset values:** `cnt`=0, `mdu_busy`=0, `mdu_done`=0, all counters=0.
  - Combinational outputs follow their inputs during reset, except that mdustall uses `mdu_busy`=0.

## Timing
- Forwarding selects and stall/flush outputs are combinational, with zero-cycle latency.
- **Multiply:** `mdu_start_exe` in cycle T → `mdu_busy`=1 in cycles T+1…T+`MUL_LAT` → `mdu_done`=1 in cycle T+`MUL_LAT`+1.
- **Divide:** same as multiply, with `DIV_LAT` in place of `MUL_LAT`.
- An mfhi in ID during cycles T…T+LAT stalls, and is released in cycle T+LAT+1.
- **Reset mid-operation:** clears `cnt` immediately (asynchronous). A pending mfhi is released in the same cycle.
- `stat_clr` and a cause asserted in the same cycle: the counter reads 0 after the edge.

## Structure
- Shared package `hazard_pkg`:
  - forwarding-select constants `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10
  - counter-width function for `DIV_LAT`
- One sub-module, `sat_counter` (parameter `W`; inputs `inc`, `clr`), instantiated three times.
- Forwarding and stall logic stay flat in the top module.

## Test plan
- **EX forwarding priority:** `rs_exe`=8, MEM and WB both write r8 → `forwardA_exe`=10. MEM `regwrite` dropped → 01. `rs_exe`=0 → 00.
- **Load-use:** lw r9 in EX (`memtoreg_exe`=1, `regaddr_exe`=9), `rt_decode`=9 → stall=1 for one cycle, `cnt_lw`=1. Same case with `regaddr_exe`=0 → no stall.
- **Branch stall:**
  - beq r3 in ID with an ALU op writing r3 in EX → branchstall for 1 cycle.
  - Next cycle, with the producer in MEM → `forwardA_decode`=1, no stall.
  - Producer is a load in MEM → stall one more cycle.
- **Divide then mfhi:** div in EX at T, mfhi held in ID → stall asserted T…T+32, `mdu_busy` T+1…T+32, `mdu_done` at T+33, `cnt_mdu`=33.
- **Kill:** `mdu_kill` at T+5 of a divide → `mdu_busy`=0 at T+6, no `mdu_done`, and the mfhi is released at T+6.
- **Saturation/clear/reset:**
  - With `STAT_W`=4 and 20 lw stall cycles → `cnt_lw`=15.
  - `stat_clr` → 0.
  - `rst` asserted mid-multiply → `mdu_busy`=0 asynchronously.
